vfifo_sc_fifo_ctrl: RTL and testbench

VFIFO_SC_FIFO_CTRL -- requirements
Module: vfifo_sc_fifo_ctrl

---
 rtl/vfifo_sc_fifo_ctrl.sv | 139 +++++++++++++
 tb/tb_vfifo_sc_fifo_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vfifo_sc_fifo_ctrl.sv
// +--------------------------------------------------------------------------+
// | vfifo_sc_fifo_ctrl : single-clock FIFO controller for an external        |
// | dual-port RAM (write port A, registered read port B).                    |
// | Optional almost-full/almost-empty flags: define VFIFO_ALMOST_FLAGS_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vfifo_sc_fifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] adr_a,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] adr_b,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fill_cnt,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ovf,
  output logic                  unf
);

  localparam logic [ADDR_WIDTH:0] C_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] fill_cnt_q, fill_cnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                w_full, w_empty, w_wr_acc, w_rd_acc;

  // MSB is the wrap toggle: equal low bits with differing MSBs means a full lap.
  assign w_full   = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_wr_acc = wr_req & ~w_full & ~flush;
  assign w_rd_acc = rd_req & ~w_empty & ~flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_cnt_d = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end else begin
      if (w_wr_acc) wr_ptr_d = wr_ptr_q + C_ONE;
      if (w_rd_acc) rd_ptr_d = rd_ptr_q + C_ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   fill_cnt_d = fill_cnt_q + C_ONE;
        2'b01:   fill_cnt_d = fill_cnt_q - C_ONE;
        default: fill_cnt_d = fill_cnt_q;
      endcase
      // RAM samples adr_b at the accept edge, so q_b is valid one cycle later.
      rd_valid_d = w_rd_acc;
      ovf_d      = ovf_q | (wr_req & w_full);
      unf_d      = unf_q | (rd_req & w_empty);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign adr_a    = wr_ptr_q[ADDR_WIDTH-1:0];
  assign adr_b    = rd_ptr_q[ADDR_WIDTH-1:0];
  assign we_a     = w_wr_acc;
  assign rd_valid = rd_valid_q;
  assign full     = w_full;
  assign empty    = w_empty;
  assign fill_cnt = fill_cnt_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

`ifdef VFIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] C_AF_THR = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] C_AE_THR = AE_LEVEL[ADDR_WIDTH:0];

  logic almost_full_q, almost_full_d;
  logic almost_empty_q, almost_empty_d;

  // Compared against the next count so the flags line up with fill_cnt.
  always_comb begin
    almost_full_d  = (fill_cnt_d >= C_AF_THR);
    almost_empty_d = (fill_cnt_d <= C_AE_THR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{AF_LEVEL, AE_LEVEL};
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vfifo_sc_fifo_ctrl.sv
// Scoreboard bench for vfifo_sc_fifo_ctrl with a behavioural RAM (ADDR_WIDTH=3).
`default_nettype none

module tb_vfifo_sc_fifo_ctrl;

`ifdef VFIFO_ALMOST_FLAGS_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic       clk, rst, wr_req, rd_req, flush;
  logic [2:0] adr_a, adr_b;
  logic       we_a, rd_valid, full, empty, almost_full, almost_empty, ovf, unf;
  logic [3:0] fill_cnt;
  logic [7:0] wr_data, q_b;
  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  int         n_err, n_checks;

  vfifo_sc_fifo_ctrl #(.ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .flush(flush),
    .adr_a(adr_a), .we_a(we_a), .adr_b(adr_b), .rd_valid(rd_valid),
    .full(full), .empty(empty), .fill_cnt(fill_cnt),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we_a) mem[adr_a] <= wr_data;
    q_b <= mem[adr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every rd_valid cycle must present the oldest outstanding word.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_data: got %0h with rd_valid but none expected", q_b);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (q_b !== e) begin
          n_err++;
          $display("FAIL rd_data: got %0h expected %0h", q_b, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_io(input bit w, input bit r, input logic [7:0] d, input bit exp_we);
    wr_req  = w;
    rd_req  = r;
    wr_data = d;
    #1;
    chk("we_a", {31'd0, we_a}, {31'd0, exp_we});
    if (exp_we) exp_q.push_back(d);
    step();
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    n_err = 0; n_checks = 0;
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; wr_data = 8'h00;
    repeat (2) step();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_fill", {28'd0, fill_cnt}, 32'd0);
    chk("rst_ae", {31'd0, almost_empty}, {31'd0, ALM});
    chk("rst_af", {31'd0, almost_full}, 32'd0);
    chk("rst_rdv", {31'd0, rd_valid}, 32'd0);
    rst = 1'b0;
    step();

    // First write lands at address 0.
    wr_req = 1'b1; wr_data = 8'hA5;
    #1;
    chk("first_adr_a", {29'd0, adr_a}, 32'd0);
    step_io(1'b1, 1'b0, 8'hA5, 1'b1);
    chk("first_fill", {28'd0, fill_cnt}, 32'd1);
    chk("first_empty", {31'd0, empty}, 32'd0);

    for (int i = 1; i < 8; i++) begin
      step_io(1'b1, 1'b0, 8'h10 + 8'(i), 1'b1);
      chk("fill_up", {28'd0, fill_cnt}, 32'(i + 1));
      chk("af_up", {31'd0, almost_full}, {31'd0, ALM && (i + 1 >= 6)});
    end
    chk("full_set", {31'd0, full}, 32'd1);

    step_io(1'b1, 1'b0, 8'hEE, 1'b0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("ovf_fill", {28'd0, fill_cnt}, 32'd8);
    step();
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Full with both requests: only the read goes through.
    step_io(1'b1, 1'b1, 8'hEF, 1'b0);
    chk("full_rw_fill", {28'd0, fill_cnt}, 32'd7);
    chk("full_rw_full", {31'd0, full}, 32'd0);

    for (int i = 0; i < 4; i++) step_io(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain3", {28'd0, fill_cnt}, 32'd3);

    for (int i = 0; i < 20; i++) begin
      step_io(1'b1, 1'b1, 8'h40 + 8'(i), 1'b1);
      chk("stream_fill", {28'd0, fill_cnt}, 32'd3);
    end

    step_io(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain2_ae", {31'd0, almost_empty}, 32'd0);
    step_io(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain1_fill", {28'd0, fill_cnt}, 32'd1);
    chk("drain1_ae", {31'd0, almost_empty}, {31'd0, ALM});
    chk("drain1_af", {31'd0, almost_full}, 32'd0);
    step_io(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain0_empty", {31'd0, empty}, 32'd1);

    step_io(1'b0, 1'b1, 8'h00, 1'b0);
    chk("unf_rdv", {31'd0, rd_valid}, 32'd0);
    chk("unf_set", {31'd0, unf}, 32'd1);
    step();
    chk("unf_sticky", {31'd0, unf}, 32'd1);

    // Flush with pending data and a concurrent write request.
    step_io(1'b1, 1'b0, 8'h55, 1'b1);
    step_io(1'b1, 1'b0, 8'h66, 1'b1);
    wr_req = 1'b1; flush = 1'b1; wr_data = 8'h99;
    #1;
    chk("flush_we", {31'd0, we_a}, 32'd0);
    step();
    wr_req = 1'b0; flush = 1'b0;
    exp_q.delete();
    chk("flush_unf", {31'd0, unf}, 32'd0);
    chk("flush_ovf", {31'd0, ovf}, 32'd0);
    chk("flush_fill", {28'd0, fill_cnt}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);

    // Reset arrives while an accepted read is in flight.
    step_io(1'b1, 1'b0, 8'h77, 1'b1);
    step_io(1'b0, 1'b1, 8'h00, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_rdv", {31'd0, rd_valid}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_rdv", {31'd0, rd_valid}, 32'd0);
    chk("post_rst_empty", {31'd0, empty}, 32'd1);
    chk("post_rst_fill", {28'd0, fill_cnt}, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
